// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its FIFO.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } sb_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store FIFO with a youngest-match associative lookup for load forwarding.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  logic [TAG_W-1:0]  enq_tag,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              full_c,
  output logic              empty_c,
  output logic [TAG_W-1:0]  head_tag_c,
  output logic [DATA_W-1:0] head_data_c,
  output logic              hit_c,
  output logic [DATA_W-1:0] hit_data_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] idx;
  logic             enq_ok;
  logic             deq_ok;

  assign full_c      = (count == CNT_W'(DEPTH));
  assign empty_c     = (count == '0);
  assign enq_ok      = enq && !full_c;
  assign deq_ok      = deq && !empty_c;
  assign head_tag_c  = mem[rd_ptr].tag;
  assign head_data_c = mem[rd_ptr].data;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq_ok, deq_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_ptr] <= '{tag: enq_tag, data: enq_data};
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_c      = 1'b0;
    hit_data_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[idx].tag == lookup_tag)) begin
        hit_c      = 1'b1;
        hit_data_c = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// CPU-side store buffer: queues stores, forwards load hits, and owns the single memory port.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  sb_state_t         state;
  logic [DATA_W-1:0] rdata_q;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [TAG_W-1:0]  head_tag_c;
  logic [DATA_W-1:0] head_data_c;
  logic              hit_c;
  logic [DATA_W-1:0] hit_data_c;
  logic              store_c;
  logic              miss_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // A simultaneous load wins; the store is dropped.
  assign store_c  = memwrite && !memread;
  assign miss_c   = memread && !hit_c;
  assign stall    = (store_c && fifo_full_c) || (miss_c && (state != RESP));
  assign readdata = (state == RESP) ? rdata_q : hit_data_c;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .enq         (store_c),
    .enq_tag     (addr[31:2]),
    .enq_data    (writedata),
    .deq         ((state == WRITE) && mem_ack),
    .lookup_tag  (addr[31:2]),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c),
    .head_tag_c  (head_tag_c),
    .head_data_c (head_data_c),
    .hit_c       (hit_c),
    .hit_data_c  (hit_data_c)
  );

  // Memory port sequencer; load misses outrank drains when leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_c) begin
            state    <= READ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {addr[31:2], 2'b00};
          end else if (!fifo_empty_c) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {head_tag_c, 2'b00};
            mem_wdata <= head_data_c;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        READ: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            rdata_q <= mem_rdata;
          end
        end
        RESP: state <= IDLE;
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized self-checking bench for store_buffer against a queue-based store/memory model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_delay = 1;
  logic inject_ack = 1'b0;
  int wait_cnt = 0;
  int n_wr = 0;
  int n_rd = 0;
  int rd_ack_cyc = -10;
  int wr_at_read = 0;
  int checked = 0;
  int last_stalls = 0;
  logic [31:0] rd_addr_last = '0;
  logic [31:0] tb_mem [logic [29:0]];
  logic [63:0] wr_log [$];
  logic [63:0] exp_st [$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (tb_mem.exists(a[31:2])) return tb_mem[a[31:2]];
    if (a[31:2] == 30'h0C0) return 32'h0000CAFE;
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Memory: acks each request after ack_delay idle negedges, logs writes and reads.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (reset) begin
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          wr_log.push_back({mem_addr, mem_wdata});
          tb_mem[mem_addr[31:2]] = mem_wdata;
          n_wr++;
        end else begin
          mem_rdata    = mem_word(mem_addr);
          rd_addr_last = mem_addr;
          rd_ack_cyc   = cyc;
          wr_at_read   = n_wr;
          n_rd++;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (inject_ack) mem_ack = 1'b1;
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    logic exp_stall;
    last_stalls = 0;
    memwrite = 1'b1; memread = 1'b0; addr = a; writedata = d;
    forever begin
      #1;
      exp_stall = (exp_st.size() - n_wr) >= DEPTH;
      tests++;
      if (stall !== exp_stall) begin
        fails++;
        $display("FAIL store_stall addr=%h got=%b want=%b", a, stall, exp_stall);
      end
      if (stall !== 1'b1) break;
      last_stalls++;
      if (last_stalls > 300) begin
        tests++; fails++;
        $display("FAIL store_timeout addr=%h got=stuck want=accepted", a);
        break;
      end
      @(posedge clk); #1;
    end
    exp_st.push_back({a[31:2], 2'b00, d});
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    logic hit;
    logic [31:0] exp_d;
    int waited;
    hit = 1'b0;
    exp_d = mem_word(a);
    for (int i = n_wr; i < exp_st.size(); i++)
      if (exp_st[i][63:34] == a[31:2]) begin hit = 1'b1; exp_d = exp_st[i][31:0]; end
    memread = 1'b1; memwrite = 1'b0; addr = a;
    #1;
    tests++;
    if (stall !== !hit) begin
      fails++;
      $display("FAIL load_stall addr=%h got=%b want=%b", a, stall, !hit);
    end
    if (!hit) begin
      waited = 0;
      while (stall === 1'b1 && waited < 300) begin @(posedge clk); #2; waited++; end
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL load_timeout addr=%h got=%b want=0", a, stall); end
      tests++;
      if (cyc != rd_ack_cyc + 1) begin
        fails++; $display("FAIL load_latency addr=%h got_cyc=%0d want_cyc=%0d", a, cyc, rd_ack_cyc + 1);
      end
      tests++;
      if (rd_addr_last !== {a[31:2], 2'b00}) begin
        fails++; $display("FAIL load_addr got=%h want=%h", rd_addr_last, {a[31:2], 2'b00});
      end
    end
    tests++;
    if (readdata !== exp_d) begin
      fails++; $display("FAIL load_data addr=%h got=%h want=%h", a, readdata, exp_d);
    end
    @(posedge clk); #1;
    memread = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((n_wr != exp_st.size() || mem_req !== 1'b0) && waited < 500) begin
      @(posedge clk); #1; waited++;
    end
    tests++;
    if (n_wr != exp_st.size()) begin
      fails++; $display("FAIL drain_count got=%0d want=%0d", n_wr, exp_st.size());
    end
    for (int i = checked; i < exp_st.size() && i < wr_log.size(); i++) begin
      tests++;
      if (wr_log[i] !== exp_st[i]) begin
        fails++; $display("FAIL drain_order idx=%0d got=%h want=%h", i, wr_log[i], exp_st[i]);
      end
    end
    checked = exp_st.size();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    memwrite = 1'b1; addr = 32'h40; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_store_stall got=%b want=0", stall); end
    memwrite = 1'b0; memread = 1'b1; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_load_stall got=%b want=1", stall); end
    memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_forward();
    int n0;
    ack_delay = 2;
    n0 = n_rd;
    do_store(32'h100, 32'h11);
    do_load(32'h100);
    do_load(32'h103);
    wait_drain();
    tests++;
    if (n_rd != n0) begin fails++; $display("FAIL fwd_no_read got=%0d want=%0d", n_rd, n0); end
  endtask

  task automatic test_youngest();
    ack_delay = 2;
    do_store(32'h200, 32'hA);
    do_store(32'h200, 32'hB);
    do_load(32'h200);
    wait_drain();
  endtask

  task automatic test_full_stall();
    ack_delay = 3;
    for (int i = 0; i < 5; i++) do_store(32'h700 + 32'(4 * i), 32'h50 + 32'(i));
    tests++;
    if (last_stalls == 0) begin fails++; $display("FAIL full_fifth_stall got=0 want=>0"); end
    wait_drain();
  endtask

  task automatic test_miss_during_write();
    int waited = 0;
    int n0;
    ack_delay = 3;
    do_store(32'h400, 32'h1234);
    do_store(32'h404, 32'h5678);
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && waited < 50) begin @(posedge clk); #1; waited++; end
    tests++;
    if (!(mem_req === 1'b1 && mem_we === 1'b1)) begin fails++; $display("FAIL mdw_write_active got=%b want=1", mem_req); end
    n0 = n_wr;
    do_load(32'h300);
    tests++;
    if (wr_at_read != n0 + 1) begin fails++; $display("FAIL mdw_read_order got=%0d want=%0d", wr_at_read, n0 + 1); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int n0;
    ack_delay = 50;
    do_store(32'h500, $urandom);
    do_store(32'h504, $urandom);
    do_store(32'h508, $urandom);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmid_pending got=%b want=1", mem_req); end
    reset = 1'b1; #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_mem_req got=%b want=0", mem_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rmid_mem_addr got=%h want=0", mem_addr); end
    @(posedge clk); #1;
    while (exp_st.size() > n_wr) void'(exp_st.pop_back());
    checked = n_wr;
    n0 = n_wr;
    reset = 1'b0;
    inject_ack = 1'b1;
    @(posedge clk); #1;
    inject_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_stale_ack cyc=%0d got=%b want=0", i, mem_req); end
    end
    ack_delay = 1;
    do_load(32'h504);
    wait_drain();
    tests++; if (n_wr != n0) begin fails++; $display("FAIL rmid_dropped got=%0d want=%0d", n_wr, n0); end
  endtask

  task automatic test_wrap();
    int nst = 0;
    while (nst < 14) begin
      ack_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        do_load(32'h600 + 32'(4 * $urandom_range(0, 7)));
      end else begin
        do_store(32'h600 + 32'(4 * $urandom_range(0, 7)), $urandom);
        nst++;
      end
    end
    wait_drain();
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; memread = 1'b0; addr = '0; writedata = '0;
    test_reset();
    test_forward();
    test_youngest();
    test_full_stall();
    test_miss_during_write();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
